// File: rtl/drive_pwm_sequencer.sv
// rtl/drive_pwm_sequencer.sv - shared-counter PWM drive sequencer with collision resume and junction manoeuvre
module drive_pwm_sequencer #(
    parameter int CLK_HZ             = 50_000_000,
    parameter int PWM_HZ             = 80,
    parameter int CNT_W              = 20,
    parameter int DUTY_FULL          = 30,
    parameter int DUTY_VEER          = 30,
    parameter int DUTY_HARD          = 80,
    parameter int DUTY_NINETY        = 40,
    parameter int DUTY_NINETY_FAST   = 42,
    parameter int RESUME_PERIODS     = 40,
    parameter int TURN_PERIODS       = 60,
    parameter int TD_TIMEOUT_PERIODS = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dir_ctrl,
    input  logic       col_n,
    input  logic       col_force,
    input  logic       rev_req,
    input  logic       td_valid,
    input  logic [2:0] td_dir,
    output logic       hb_en_a,
    output logic       hb_en_b,
    output logic [3:0] hb_in,
    output logic [2:0] state,
    output logic       pwm_tick
);
    localparam int PERIOD  = CLK_HZ / PWM_HZ;
    localparam int MAX_RT  = (RESUME_PERIODS > TURN_PERIODS) ? RESUME_PERIODS : TURN_PERIODS;
    localparam int MAX_PER = (MAX_RT > TD_TIMEOUT_PERIODS) ? MAX_RT : TD_TIMEOUT_PERIODS;
    localparam int PER_W   = $clog2(MAX_PER + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CMP_FULL  = CNT_W'(PERIOD * DUTY_FULL / 100);
    localparam logic [CNT_W-1:0] CMP_VEER  = CNT_W'(PERIOD * DUTY_VEER / 100);
    localparam logic [CNT_W-1:0] CMP_HARD  = CNT_W'(PERIOD * DUTY_HARD / 100);
    localparam logic [CNT_W-1:0] CMP_NIN   = CNT_W'(PERIOD * DUTY_NINETY / 100);
    localparam logic [CNT_W-1:0] CMP_FAST  = CNT_W'(PERIOD * DUTY_NINETY_FAST / 100);

    localparam logic [PER_W-1:0] RESUME_LAST = PER_W'(RESUME_PERIODS - 1);
    localparam logic [PER_W-1:0] TURN_LAST   = PER_W'(TURN_PERIODS - 1);
    localparam logic [PER_W-1:0] TOUT_LAST   = PER_W'(TD_TIMEOUT_PERIODS - 1);
    localparam logic [PER_W-1:0] PER_MAX     = {PER_W{1'b1}};

    localparam logic [3:0] PAT_FWD = 4'b0110;
    localparam logic [3:0] PAT_REV = 4'b1001;
    localparam logic [3:0] PAT_SPL = 4'b1010;
    localparam logic [3:0] PAT_SPR = 4'b0101;
    localparam logic [3:0] PAT_OFF = 4'b0000;

    localparam logic [2:0] D_OFF  = 3'd0;
    localparam logic [2:0] D_FULL = 3'd1;
    localparam logic [2:0] D_VEER = 3'd2;
    localparam logic [2:0] D_HARD = 3'd3;
    localparam logic [2:0] D_NIN  = 3'd4;
    localparam logic [2:0] D_FAST = 3'd5;

    typedef enum logic [2:0] {
        S_FWD    = 3'd0,
        S_REV    = 3'd1,
        S_COLL   = 3'd2,
        S_JWAIT  = 3'd3,
        S_JEXEC  = 3'd4,
        S_HALT   = 3'd5,
        S_RESUME = 3'd6
    } state_t;

    state_t           curState, nextState;
    logic [CNT_W-1:0] cnt;
    logic [PER_W-1:0] perCnt;
    logic [2:0]       latDir;
    logic [2:0]       selA, selB, nSelA, nSelB;
    logic [3:0]       pat, nPat;
    logic             latchDir;
    logic             coll;
    logic             tick;

    function automatic logic [CNT_W-1:0] cmpOf(input logic [2:0] d);
        case (d)
            D_FULL:  cmpOf = CMP_FULL;
            D_VEER:  cmpOf = CMP_VEER;
            D_HARD:  cmpOf = CMP_HARD;
            D_NIN:   cmpOf = CMP_NIN;
            D_FAST:  cmpOf = CMP_FAST;
            default: cmpOf = '0;
        endcase
    endfunction

    assign coll     = !col_n | col_force;
    assign tick     = (cnt == CNT_LAST);
    assign pwm_tick = tick;
    assign state    = curState;

    always_comb begin
        nextState = curState;
        latchDir  = 1'b0;
        case (curState)
            S_FWD: begin
                if (coll)                nextState = S_COLL;
                else if (rev_req)        nextState = S_REV;
                else if (&dir_ctrl[3:2]) nextState = S_JWAIT;
            end
            S_REV: begin
                if (coll)          nextState = S_COLL;
                else if (!rev_req) nextState = S_FWD;
            end
            S_COLL: begin
                if (!coll) nextState = S_RESUME;
            end
            S_RESUME: begin
                if (coll)                               nextState = S_COLL;
                else if (tick && perCnt == RESUME_LAST) nextState = S_FWD;
            end
            S_JWAIT: begin
                // A tone result wins over a timeout tick arriving in the same cycle
                if (coll) begin
                    nextState = S_COLL;
                end else if (td_valid) begin
                    if (td_dir > 3'd4) begin
                        nextState = S_HALT;
                    end else begin
                        nextState = S_JEXEC;
                        latchDir  = 1'b1;
                    end
                end else if (tick && perCnt == TOUT_LAST) begin
                    nextState = S_HALT;
                end
            end
            S_JEXEC: begin
                if (coll)                             nextState = S_COLL;
                else if (latDir == 3'd4)              nextState = S_HALT;
                else if (tick && perCnt == TURN_LAST) nextState = S_FWD;
            end
            S_HALT:  nextState = S_HALT;
            default: nextState = S_FWD;
        endcase
    end

    always_comb begin
        nSelA = selA;
        nSelB = selB;
        nPat  = pat;
        case (curState)
            S_FWD: begin
                case (dir_ctrl)
                    4'b0000: {nSelA, nSelB, nPat} = {D_FULL, D_FULL, PAT_FWD};
                    4'b0101: {nSelA, nSelB, nPat} = {D_VEER, D_FULL, PAT_FWD};
                    4'b0110: {nSelA, nSelB, nPat} = {D_VEER, D_HARD, PAT_SPL};
                    4'b0111: {nSelA, nSelB, nPat} = {D_NIN,  D_FAST, PAT_SPL};
                    4'b1001: {nSelA, nSelB, nPat} = {D_FULL, D_VEER, PAT_FWD};
                    4'b1010: {nSelA, nSelB, nPat} = {D_HARD, D_VEER, PAT_SPR};
                    4'b1011: {nSelA, nSelB, nPat} = {D_FAST, D_NIN,  PAT_SPR};
                    default: ;
                endcase
            end
            S_REV: begin
                case (dir_ctrl)
                    4'b0000: {nSelA, nSelB, nPat} = {D_FULL, D_FULL, PAT_REV};
                    4'b0101: {nSelA, nSelB, nPat} = {D_FULL, D_VEER, PAT_REV};
                    4'b0110: {nSelA, nSelB, nPat} = {D_VEER, D_HARD, PAT_SPR};
                    4'b0111: {nSelA, nSelB, nPat} = {D_NIN,  D_FAST, PAT_SPR};
                    4'b1001: {nSelA, nSelB, nPat} = {D_VEER, D_FULL, PAT_REV};
                    4'b1010: {nSelA, nSelB, nPat} = {D_HARD, D_VEER, PAT_SPL};
                    4'b1011: {nSelA, nSelB, nPat} = {D_FAST, D_NIN,  PAT_SPL};
                    4'b1100, 4'b1101, 4'b1110, 4'b1111:
                             {nSelA, nSelB, nPat} = {D_OFF,  D_OFF,  PAT_OFF};
                    default: ;
                endcase
            end
            S_JEXEC: begin
                case (latDir)
                    3'd0:    {nSelA, nSelB, nPat} = {D_FULL, D_FULL, PAT_FWD};
                    3'd1:    {nSelA, nSelB, nPat} = {D_NIN,  D_FAST, PAT_SPL};
                    3'd2:    {nSelA, nSelB, nPat} = {D_FAST, D_NIN,  PAT_SPR};
                    3'd3:    {nSelA, nSelB, nPat} = {D_FULL, D_FULL, PAT_REV};
                    default: {nSelA, nSelB, nPat} = {D_OFF,  D_OFF,  PAT_OFF};
                endcase
            end
            default: {nSelA, nSelB, nPat} = {D_OFF, D_OFF, PAT_OFF};
        endcase
        // Entering COLL or HALT kills the bridge on the very next clock, whatever the PWM phase
        if (nextState == S_COLL || nextState == S_HALT) begin
            {nSelA, nSelB, nPat} = {D_OFF, D_OFF, PAT_OFF};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            curState <= S_FWD;
            perCnt   <= '0;
            latDir   <= 3'd0;
            selA     <= D_OFF;
            selB     <= D_OFF;
            pat      <= PAT_OFF;
            hb_en_a  <= 1'b0;
            hb_en_b  <= 1'b0;
            hb_in    <= PAT_OFF;
        end else begin
            cnt      <= tick ? '0 : cnt + 1'b1;
            curState <= nextState;
            if (nextState != curState) begin
                perCnt <= '0;
            end else if (tick && perCnt != PER_MAX) begin
                perCnt <= perCnt + 1'b1;
            end
            if (latchDir) begin
                latDir <= td_dir;
            end
            selA    <= nSelA;
            selB    <= nSelB;
            pat     <= nPat;
            hb_en_a <= (cnt < cmpOf(nSelA));
            hb_en_b <= (cnt < cmpOf(nSelB));
            hb_in   <= nPat;
        end
    end
endmodule

// File: tb/tb_drive_pwm_sequencer.sv
// tb/tb_drive_pwm_sequencer.sv - directed and randomized bench with behavioural drive model
module tb_drive_pwm_sequencer;
    localparam int PERIOD = 10;
    localparam int RES    = 2;
    localparam int TURN   = 3;
    localparam int TOUT   = 4;
    localparam int P_FULL = 30;
    localparam int P_VEER = 30;
    localparam int P_HARD = 80;
    localparam int P_NIN  = 40;
    localparam int P_FAST = 42;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dir_ctrl;
    logic       col_n, col_force, rev_req, td_valid;
    logic [2:0] td_dir;
    logic       hb_en_a, hb_en_b, pwm_tick;
    logic [3:0] hb_in;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    int fwdA[16], fwdB[16], fwdPat[16];
    bit fwdOk[16];
    int mCnt, mSt, mPer, mLat, mDa, mDb, mPat;
    int eA, eB, eHb;

    drive_pwm_sequencer #(
        .CLK_HZ(1000), .PWM_HZ(100), .CNT_W(20),
        .DUTY_FULL(P_FULL), .DUTY_VEER(P_VEER), .DUTY_HARD(P_HARD),
        .DUTY_NINETY(P_NIN), .DUTY_NINETY_FAST(P_FAST),
        .RESUME_PERIODS(RES), .TURN_PERIODS(TURN), .TD_TIMEOUT_PERIODS(TOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir_ctrl(dir_ctrl), .col_n(col_n),
        .col_force(col_force), .rev_req(rev_req), .td_valid(td_valid),
        .td_dir(td_dir), .hb_en_a(hb_en_a), .hb_en_b(hb_en_b),
        .hb_in(hb_in), .state(state), .pwm_tick(pwm_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setEntry(input int d, input int a, input int b, input int p);
        fwdOk[d] = 1'b1; fwdA[d] = a; fwdB[d] = b; fwdPat[d] = p;
    endtask

    task automatic initTables();
        for (int i = 0; i < 16; i++) begin
            fwdOk[i] = 1'b0; fwdA[i] = 0; fwdB[i] = 0; fwdPat[i] = 0;
        end
        setEntry(4'b0000, P_FULL, P_FULL, 4'b0110);
        setEntry(4'b0101, P_VEER, P_FULL, 4'b0110);
        setEntry(4'b0110, P_VEER, P_HARD, 4'b1010);
        setEntry(4'b0111, P_NIN,  P_FAST, 4'b1010);
        setEntry(4'b1001, P_FULL, P_VEER, 4'b0110);
        setEntry(4'b1010, P_HARD, P_VEER, 4'b0101);
        setEntry(4'b1011, P_FAST, P_NIN,  4'b0101);
    endtask

    function automatic int mirror(input int p);
        case (p)
            6:       return 9;
            9:       return 6;
            10:      return 5;
            5:       return 10;
            default: return p;
        endcase
    endfunction

    task automatic modelReset();
        mCnt = 0; mSt = 0; mPer = 0; mLat = 0;
        mDa = 0; mDb = 0; mPat = 0;
        eA = 0; eB = 0; eHb = 0;
    endtask

    // One clock of the drive behaviour, evaluated from the inputs present before the edge
    task automatic modelStep();
        bit tick, c;
        int nx, d;
        tick = (mCnt == PERIOD - 1);
        c    = !col_n || col_force;
        d    = int'(dir_ctrl);
        nx   = mSt;
        if (c && mSt != 2 && mSt != 5) nx = 2;
        else case (mSt)
            0: if (rev_req) nx = 1; else if (d >= 12) nx = 3;
            1: if (!rev_req) nx = 0;
            2: if (!c) nx = 6;
            6: if (tick && mPer + 1 == RES) nx = 0;
            3: if (td_valid) nx = (td_dir <= 4) ? 4 : 5;
               else if (tick && mPer + 1 == TOUT) nx = 5;
            4: if (mLat == 4) nx = 5; else if (tick && mPer + 1 == TURN) nx = 0;
            default: ;
        endcase
        case (mSt)
            0: if (fwdOk[d]) begin mDa = fwdA[d]; mDb = fwdB[d]; mPat = fwdPat[d]; end
            1: begin
                if (d >= 12) begin
                    mDa = 0; mDb = 0; mPat = 0;
                end else if (fwdOk[d]) begin
                    if (d % 4 == 1) begin mDa = fwdB[d]; mDb = fwdA[d]; end
                    else begin mDa = fwdA[d]; mDb = fwdB[d]; end
                    mPat = mirror(fwdPat[d]);
                end
            end
            4: case (mLat)
                0: begin mDa = P_FULL; mDb = P_FULL; mPat = 6;  end
                1: begin mDa = P_NIN;  mDb = P_FAST; mPat = 10; end
                2: begin mDa = P_FAST; mDb = P_NIN;  mPat = 5;  end
                3: begin mDa = P_FULL; mDb = P_FULL; mPat = 9;  end
                default: begin mDa = 0; mDb = 0; mPat = 0; end
            endcase
            default: begin mDa = 0; mDb = 0; mPat = 0; end
        endcase
        if (nx == 2 || nx == 5) begin mDa = 0; mDb = 0; mPat = 0; end
        eA  = int'(mCnt < PERIOD * mDa / 100);
        eB  = int'(mCnt < PERIOD * mDb / 100);
        eHb = mPat;
        if (mSt == 3 && nx == 4) mLat = int'(td_dir);
        if (nx != mSt) mPer = 0;
        else if (tick && mPer < 7) mPer = mPer + 1;
        mCnt = tick ? 0 : mCnt + 1;
        mSt  = nx;
    endtask

    task automatic cyc(input string tag);
        modelStep();
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_state"}, 32'(state), 32'(mSt));
        chk({tag, "_hb_in"}, 32'(hb_in), 32'(eHb));
        chk({tag, "_en_a"}, 32'(hb_en_a), 32'(eA));
        chk({tag, "_en_b"}, 32'(hb_en_b), 32'(eB));
        chk({tag, "_tick"}, 32'(pwm_tick), 32'(mCnt == PERIOD - 1));
    endtask

    task automatic idleInputs();
        dir_ctrl = 4'b0000; col_n = 1'b1; col_force = 1'b0;
        rev_req = 1'b0; td_valid = 1'b0; td_dir = 3'b000;
    endtask

    task automatic randInputs();
        dir_ctrl  = 4'($urandom_range(0, 15));
        col_n     = ($urandom_range(0, 19) != 0);
        col_force = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 9) == 0) rev_req = ~rev_req;
        td_valid  = ($urandom_range(0, 7) == 0);
        td_dir    = 3'($urandom_range(0, 7));
    endtask

    // Called at a falling edge; asserts reset mid-cycle and checks outputs without any clock edge
    task automatic doReset(input string tag);
        idleInputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_state"}, 32'(state), 32'd0);
        chk({tag, "_rst_hb_in"}, 32'(hb_in), 32'd0);
        chk({tag, "_rst_en"}, 32'({hb_en_a, hb_en_b}), 32'd0);
        chk({tag, "_rst_tick"}, 32'(pwm_tick), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nA, nB, nT, n4, n6, nL;
        bit done;
        initTables();
        idleInputs();
        rst_n = 1'b0;
        @(negedge clk);
        chk("init_state", 32'(state), 32'd0);
        chk("init_hb_in", 32'(hb_in), 32'd0);
        chk("init_en", 32'({hb_en_a, hb_en_b}), 32'd0);
        chk("init_tick", 32'(pwm_tick), 32'd0);
        modelReset();
        rst_n = 1'b1;

        nA = 0; nT = 0;
        for (int i = 0; i < 30; i++) begin
            cyc("straight");
            if (i >= 10) begin nA += hb_en_a; nT += pwm_tick; end
        end
        chk("straight_pattern", 32'(hb_in), 32'b0110);
        chk("full_duty_count", 32'(nA), 32'd6);
        chk("tick_count", 32'(nT), 32'd2);

        dir_ctrl = 4'b0110;
        cyc("hardl_settle");
        nB = 0;
        for (int i = 0; i < 10; i++) begin cyc("hardl"); nB += hb_en_b; end
        chk("hardl_pattern", 32'(hb_in), 32'b1010);
        chk("hard_duty_count", 32'(nB), 32'd8);

        rev_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("rev_hard");
        chk("rev_state", 32'(state), 32'd1);
        chk("rev_hard_pattern", 32'(hb_in), 32'b0101);

        rev_req = 1'b0; dir_ctrl = 4'b0000;
        for (int i = 0; i < 3; i++) cyc("back_fwd");
        col_n = 1'b0;
        cyc("coll_enter");
        chk("coll_state", 32'(state), 32'd2);
        chk("coll_enables", 32'({hb_en_a, hb_en_b}), 32'd0);
        for (int i = 0; i < 3; i++) cyc("coll_hold");
        col_n = 1'b1;
        n6 = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cyc("resume");
            if (state == 3'd6) n6++;
            if (state == 3'd0) done = 1'b1;
        end
        chk("resume_exit", 32'(done), 32'd1);
        chk("resume_length", 32'(n6 >= 11 && n6 <= 20), 32'd1);

        dir_ctrl = 4'b1100;
        cyc("jwait_enter");
        chk("jwait_state", 32'(state), 32'd3);
        dir_ctrl = 4'b0000;
        cyc("jwait");
        td_valid = 1'b1; td_dir = 3'b001;
        cyc("jexec_enter");
        td_valid = 1'b0; td_dir = 3'b000;
        chk("jexec_state", 32'(state), 32'd4);
        n4 = 1; nL = 0; done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            cyc("jexec_left");
            if (state == 3'd4) n4++;
            if (hb_in == 4'b1010) nL++;
            if (state == 3'd0) done = 1'b1;
        end
        chk("jexec_exit", 32'(done), 32'd1);
        chk("jexec_left_cycles", 32'(nL), 32'(n4));
        chk("jexec_length", 32'(n4 >= 21 && n4 <= 30), 32'd1);

        dir_ctrl = 4'b1100;
        cyc("timeout_enter");
        dir_ctrl = 4'b0000;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cyc("timeout_wait");
            if (state == 3'd5) done = 1'b1;
        end
        chk("timeout_halt", 32'(done), 32'd1);
        for (int i = 0; i < 20; i++) begin
            randInputs();
            cyc("halt_hold");
            chk("halt_sticky", 32'(state), 32'd5);
        end
        doReset("halt_exit");
        cyc("after_halt");
        chk("after_halt_state", 32'(state), 32'd0);

        dir_ctrl = 4'b1100;
        cyc("mid_jwait");
        dir_ctrl = 4'b0000;
        td_valid = 1'b1; td_dir = 3'b010;
        cyc("mid_jexec_enter");
        td_valid = 1'b0;
        for (int i = 0; i < 5; i++) cyc("mid_jexec");
        chk("mid_jexec_pattern", 32'(hb_in), 32'b0101);
        doReset("mid_jexec");
        cyc("post_reset");
        chk("post_reset_state", 32'(state), 32'd0);

        for (int b = 0; b < 8; b++) begin
            doReset("burst");
            for (int i = 0; i < 80; i++) begin
                randInputs();
                cyc("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
